// File: rtl/csa_sub_pipe_19bit.sv
// Pipelined carry-select subtractor: term1 + ~term2 + 1, one CHUNK-bit slice resolved per stage.
// A single global advance moves every stage together; the last stage drives the outputs directly.
module csa_sub_pipe_19bit #(
  parameter int WIDTH = 19,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_sub_term1,
  input  logic [WIDTH-1:0] i_sub_term2,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
);

  localparam int NUM_STAGES = (WIDTH + CHUNK - 1) / CHUNK;

  logic [NUM_STAGES-1:0] v_q, v_d;
  logic                  adv;

  logic [WIDTH-1:0] a_s    [NUM_STAGES];
  logic [WIDTH-1:0] nb_s   [NUM_STAGES];
  logic [WIDTH-1:0] diff_s [NUM_STAGES];
  logic             bor_s  [NUM_STAGES];

  assign o_valid = v_q[NUM_STAGES-1];
  assign adv     = ~o_valid | i_ready;
  assign o_ready = adv;

  always_comb begin
    v_d = v_q;
    if (adv) v_d = {v_q[NUM_STAGES-2:0], i_valid};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) v_q <= '0;
    else       v_q <= v_d;
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;
    localparam int W  = (WIDTH - LO < CHUNK) ? (WIDTH - LO) : CHUNK;

    logic [WIDTH-1:0] a_in, nb_in, diff_in;
    logic             cin;
    logic [W:0]       sum0, sum1;
    logic [WIDTH-1:0] a_q, a_d, nb_q, nb_d, diff_q, diff_d;
    logic             bor_q, bor_d;

    if (k == 0) begin : g_first
      assign a_in    = i_sub_term1;
      assign nb_in   = ~i_sub_term2;
      assign diff_in = '0;
      assign cin     = 1'b1;
    end else begin : g_next
      assign a_in    = a_s[k-1];
      assign nb_in   = nb_s[k-1];
      assign diff_in = diff_s[k-1];
      // Stages keep the inverted carry so an all-zero reset reads as "no borrow".
      assign cin     = ~bor_s[k-1];
    end

    always_comb begin
      sum0   = {1'b0, a_in[LO +: W]} + {1'b0, nb_in[LO +: W]};
      sum1   = {1'b0, a_in[LO +: W]} + {1'b0, nb_in[LO +: W]} + {{W{1'b0}}, 1'b1};
      a_d    = a_q;
      nb_d   = nb_q;
      diff_d = diff_q;
      bor_d  = bor_q;
      if (adv) begin
        a_d              = a_in;
        nb_d             = nb_in;
        diff_d           = diff_in;
        diff_d[LO +: W]  = cin ? sum1[W-1:0] : sum0[W-1:0];
        bor_d            = ~(cin ? sum1[W] : sum0[W]);
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        a_q    <= '0;
        nb_q   <= '0;
        diff_q <= '0;
        bor_q  <= 1'b0;
      end else begin
        a_q    <= a_d;
        nb_q   <= nb_d;
        diff_q <= diff_d;
        bor_q  <= bor_d;
      end
    end

    assign a_s[k]    = a_q;
    assign nb_s[k]   = nb_q;
    assign diff_s[k] = diff_q;
    assign bor_s[k]  = bor_q;
  end

  assign o_diff   = diff_s[NUM_STAGES-1];
  assign o_borrow = bor_s[NUM_STAGES-1];

endmodule
